desync_tp: RTL

Synchronous-to-asynchronous transmitter for the two-phase (TP) dual-rail link. Accepts words from clocked logic on a valid/ready port and launches each word as one two-phase dual-rail token. The next token is held off until the far end toggles the acknowledge. It drives the same link format that the `sync` receiver consumes, so clocked test logic can feed asynchronous pipelines.

---
 rtl/async_pkg.sv | 23 ++
 rtl/desync_tp_ack_sync.sv | 33 +++
 rtl/desync_tp.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/async_pkg.sv
// Shared definitions for the two-phase dual-rail link: rail indexing, FSM states
// and the per-bit toggle pattern used to launch a token.
package async_pkg;

    localparam int RAIL_NUM = 2;
    localparam int RAIL_0   = 0;
    localparam int RAIL_1   = 1;

    typedef enum logic {
        IDLE,
        WAIT
    } desync_state_t;

    // Rail pattern that flips for one data bit: only the rail matching the value moves.
    function automatic logic [RAIL_NUM-1:0] tp_toggle_mask(input logic bit_val);
        logic [RAIL_NUM-1:0] mask;
        mask         = '0;
        mask[RAIL_1] = bit_val;
        mask[RAIL_0] = ~bit_val;
        return mask;
    endfunction

endpackage

// File: rtl/desync_tp_ack_sync.sv
// Synchronizer for the asynchronous two-phase acknowledge: a SYNC_STAGES-deep
// flop chain (at least 2), cleared asynchronously by rst.
module ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ack_i,
    output logic ack_synced
);

    logic [SYNC_STAGES-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= ack_i;
                end
            end else begin : g_chain
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign ack_synced = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/desync_tp.sv
// Clocked-to-two-phase dual-rail transmitter. Optional one-word skid buffer is
// enabled by defining DESYNC_SKID_EN.
module desync_tp
    import async_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           in_ready,
    output logic [WIDTH-1:0][RAIL_NUM-1:0] out,
    input  logic                           ack_i,
    output logic                           busy
);

    desync_state_t                  state_reg, state_next;
    logic                           phase_reg, phase_next;
    logic                           spur_reg, spur_next;
    logic                           pend_reg, pend_next;
    logic [WIDTH-1:0]               pend_data_reg, pend_data_next;
    logic [WIDTH-1:0][RAIL_NUM-1:0] out_reg, out_next;
    logic [WIDTH-1:0][RAIL_NUM-1:0] pend_mask;
    logic                           ack_synced;
    logic                           ack_level;
    logic                           complete;

    ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk        (clk),
        .rst        (rst),
        .ack_i      (ack_i),
        .ack_synced (ack_synced)
    );

`ifdef DESYNC_SKID_EN
    logic                           hold_valid_reg, hold_valid_next;
    logic [WIDTH-1:0]               hold_data_reg, hold_data_next;
    logic [WIDTH-1:0][RAIL_NUM-1:0] hold_mask;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign pend_mask[gi] = tp_toggle_mask(pend_data_reg[gi]);
`ifdef DESYNC_SKID_EN
            assign hold_mask[gi] = tp_toggle_mask(hold_data_reg[gi]);
`endif
        end
    endgenerate

    // spur_reg absorbs ack toggles seen while idle so they never count as a completion.
    assign ack_level = ack_synced ^ spur_reg;
    assign complete  = (state_reg == WAIT) && !pend_reg && (ack_level == phase_reg);

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        spur_next      = spur_reg;
        pend_next      = 1'b0;
        pend_data_next = pend_data_reg;
        out_next       = out_reg;
`ifdef DESYNC_SKID_EN
        hold_valid_next = hold_valid_reg;
        hold_data_next  = hold_data_reg;
`endif
        // The accepted word is launched one edge after acceptance.
        if (pend_reg) out_next = out_reg ^ pend_mask;

        case (state_reg)
            IDLE: begin
                if (ack_level != phase_reg) spur_next = ~spur_reg;
                if (in_valid) begin
                    pend_next      = 1'b1;
                    pend_data_next = in_data;
                    phase_next     = ~phase_reg;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
`ifdef DESYNC_SKID_EN
                if (complete) begin
                    if (hold_valid_reg) begin
                        out_next        = out_reg ^ hold_mask;
                        phase_next      = ~phase_reg;
                        hold_valid_next = 1'b0;
                    end else if (in_valid) begin
                        pend_next      = 1'b1;
                        pend_data_next = in_data;
                        phase_next     = ~phase_reg;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (in_valid && !hold_valid_reg) begin
                    hold_data_next  = in_data;
                    hold_valid_next = 1'b1;
                end
`else
                if (complete) state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= 1'b0;
            spur_reg      <= 1'b0;
            pend_reg      <= 1'b0;
            pend_data_reg <= '0;
            out_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            spur_reg      <= spur_next;
            pend_reg      <= pend_next;
            pend_data_reg <= pend_data_next;
            out_reg       <= out_next;
        end
    end

`ifdef DESYNC_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else begin
            hold_valid_reg <= hold_valid_next;
            hold_data_reg  <= hold_data_next;
        end
    end

    assign in_ready = (state_reg == IDLE) || !hold_valid_reg;
`else
    assign in_ready = (state_reg == IDLE);
`endif

    assign busy = (state_reg == WAIT);
    assign out  = out_reg;

endmodule
